// File: rtl/result_readout.sv
// Consumer end of the loader start/done handshake. It measures start-to-done latency,
// captures g/h and the latency, and steps through them on LEDs with a debounced key.
module result_readout #(
  parameter int          WIDTH    = 16,
  parameter int          DEBOUNCE = 1000,
  parameter logic [31:0] TIMEOUT  = 32'd50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             done,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             key_n,
  output logic [WIDTH-1:0] led_val,
  output logic [1:0]       idx,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam logic [WIDTH-1:0] ERR_VAL = (WIDTH == 16) ? WIDTH'(32'h0000_DEAD) : {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, SHOW, ERR} state_e;

  // key path: 2-FF synchronizer, debounce, press pulse
  logic           key_m_q, key_s_q;
  logic           db_lvl_q, db_lvl_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           press_q, press_d;

  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (key_s_q != db_lvl_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE - 1)) begin
        db_lvl_d = key_s_q;
        press_d  = ~key_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_m_q  <= 1'b1;
      key_s_q  <= 1'b1;
      db_lvl_q <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      key_m_q  <= key_n;
      key_s_q  <= key_m_q;
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // control FSM and registered outputs
  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d, cyc_q, cyc_d;
  logic [WIDTH-1:0] g_q, g_d, h_q, h_d, led_q, led_d, slot;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d, busy_q, busy_d, err_q, err_d;

  always_comb begin
    unique case (idx_q)
      2'd0:    slot = g_q;
      2'd1:    slot = h_q;
      2'd2:    slot = WIDTH'(cyc_q[15:0]);
      default: slot = WIDTH'(cyc_q[31:16]);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    g_d     = g_q;
    h_d     = h_q;
    idx_d   = idx_q;
    led_d   = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      RUN: begin
        if (!start) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = SHOW;
          g_d     = g;
          h_d     = h;
          cyc_d   = cnt_q;
          idx_d   = 2'd0;
          valid_d = 1'b1;
        end else if (cnt_q == TIMEOUT - 32'd1) begin
          state_d = ERR;
          err_d   = 1'b1;
          led_d   = ERR_VAL;
        end else begin
          cnt_d  = cnt_q + 32'd1;
          busy_d = 1'b1;
        end
      end
      SHOW: begin
        if (!start) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else begin
          valid_d = 1'b1;
          // led follows idx one cycle late, since it reads the registered idx
          led_d   = slot;
          if (press_q) idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        err_d = 1'b1;
        led_d = ERR_VAL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      g_q     <= '0;
      h_q     <= '0;
      idx_q   <= '0;
      led_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      g_q     <= g_d;
      h_q     <= h_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign led_val = led_q;
  assign idx     = idx_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_result_readout.sv
// Bench for result_readout: transaction-level model of capture, latency and slot stepping,
// with randomized latencies, results and press counts plus the directed corner cases.
module tb_result_readout;

  logic        clk = 1'b0;
  logic        rst, start, done, key_n;
  logic [15:0] g, h, led_val;
  logic [1:0]  idx;
  logic        valid, busy, err;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_slot [4];
  int          m_idx;

  result_readout #(.WIDTH(16), .DEBOUNCE(4), .TIMEOUT(32'd100)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .g(g), .h(h), .key_n(key_n),
    .led_val(led_val), .idx(idx), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key();
    key_n = 1'b0;
    step(10);
    key_n = 1'b1;
    step(10);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"}, idx, 0);
    chk({tag, "_led"}, led_val, 0);
  endtask

  // One full transaction: IDLE -> RUN for lat done-low cycles -> SHOW.
  task automatic capture(input int lat, input logic [15:0] gv, input logic [15:0] hv);
    logic [31:0] l32;
    l32 = lat;
    start = 1'b0;
    done  = 1'b0;
    step(2);
    chk_idle("pre_idle");
    g = gv;
    h = hv;
    start = 1'b1;
    step(1);
    chk("run_busy", busy, 1);
    if (lat > 0) step(lat);
    chk("run_busy_end", busy, 1);
    chk("run_valid", valid, 0);
    done = 1'b1;
    step(1);
    chk("show_valid", valid, 1);
    chk("show_busy", busy, 0);
    chk("show_idx", idx, 0);
    chk("show_led_lag", led_val, 0);
    m_slot[0] = gv;
    m_slot[1] = hv;
    m_slot[2] = l32[15:0];
    m_slot[3] = l32[31:16];
    m_idx = 0;
    step(1);
    chk("show_led_g", led_val, {16'h0, m_slot[0]});
    // later done edges and result changes must not disturb the frozen values
    g = 16'($urandom);
    h = 16'($urandom);
    done = 1'($urandom);
  endtask

  task automatic do_press(input string tag);
    press_key();
    m_idx = (m_idx + 1) % 4;
    chk({tag, "_idx"}, idx, m_idx);
    chk({tag, "_led"}, led_val, {16'h0, m_slot[m_idx]});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; done = 1'b0; key_n = 1'b1; g = '0; h = '0;
    m_idx = 0;
    #3;
    chk_idle("reset");
    chk("reset_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2);

    // basic capture and slot stepping
    capture(7, 16'h1234, 16'h0042);
    for (int i = 0; i < 4; i++) do_press("step");

    // bounce then hold: exactly one increment
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      step(2);
    end
    key_n = 1'b0;
    step(50);
    key_n = 1'b1;
    step(20);
    m_idx = (m_idx + 1) % 4;
    chk("bounce_idx", idx, m_idx);
    chk("bounce_led", led_val, {16'h0, m_slot[m_idx]});

    // randomized transactions
    for (int t = 0; t < 8; t++) begin
      capture(int'($urandom_range(0, 40)), 16'($urandom), 16'($urandom));
      for (int p = 0, n = int'($urandom_range(0, 6)); p < n; p++) do_press("rnd");
    end

    // abort with done on the same cycle
    start = 1'b0; done = 1'b0;
    step(2);
    start = 1'b1;
    step(4);
    start = 1'b0;
    done  = 1'b1;
    step(1);
    chk_idle("abort");
    step(3);
    chk_idle("abort_hold");
    done = 1'b0;

    // SHOW: start drop coincident with a press
    capture(5, 16'hBEEF, 16'h0F0F);
    key_n = 1'b0;
    step(6);
    start = 1'b0;
    step(1);
    chk("drop_press_idx", idx, 0);
    chk("drop_press_valid", valid, 0);
    step(1);
    chk("drop_press_led", led_val, 0);
    key_n = 1'b1;
    step(20);
    chk("drop_release_idx", idx, 0);

    // done already high when start rises
    done = 1'b1;
    g = 16'hA5A5;
    h = 16'h5A5A;
    step(2);
    start = 1'b1;
    step(2);
    chk("imm_valid", valid, 1);
    m_slot[0] = 16'hA5A5; m_slot[1] = 16'h5A5A; m_slot[2] = 16'h0; m_slot[3] = 16'h0;
    m_idx = 0;
    do_press("imm");
    do_press("imm");
    chk("imm_cyc", led_val, 0);

    // asynchronous reset mid-SHOW
    do_press("pre_rst");
    #2 rst = 1'b0;
    #1;
    chk_idle("async_rst");
    step(1);
    rst = 1'b1;
    start = 1'b0;
    done = 1'b0;
    step(2);

    // timeout after 100 RUN cycles, sticky
    start = 1'b1;
    step(1);
    step(99);
    chk("to_busy", busy, 1);
    chk("to_err_early", err, 0);
    step(1);
    chk("to_err", err, 1);
    chk("to_led", led_val, 16'hDEAD);
    chk("to_busy_off", busy, 0);
    done = 1'b1;
    press_key();
    press_key();
    start = 1'b0;
    step(3);
    chk("err_sticky", err, 1);
    chk("err_led", led_val, 16'hDEAD);
    chk("err_idx", idx, 0);
    chk("err_valid", valid, 0);
    #2 rst = 1'b0;
    #1;
    chk("err_rst", err, 0);
    chk("err_rst_led", led_val, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_readout.md
Name: result_readout

Overview:
- Reader/consumer end of the operand-loader start/done handshake.
- Samples `start` and `done` from the compute core and measures start-to-done latency in clock cycles.
- On `done`, captures `g`/`h` and the latency; the user steps through the captured values on LEDs with a debounced active-low key.
- Sits beside the exam compute core in the DE2 wrapper; drives LEDR[15:0] in place of the direct g/h mux.

Parameters:
- WIDTH, 16, width of g, h and led_val.
- DEBOUNCE, 1000, cycles a synchronized key level must be stable to count as pressed or released.
- TIMEOUT, 32'd50_000_000, RUN cycles without done before declaring error; legal range 1..2^32-1.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous active-low reset
- start  in  1  level from loader; high = core commanded to run
- done  in  1  level from compute core
- g  in  WIDTH  core result g
- h  in  WIDTH  core result h
- key_n  in  1  raw pushbutton, active low (KEY[0]), asynchronous to clk
- led_val  out  WIDTH  currently selected captured value
- idx  out  2  selected slot: 0=g, 1=h, 2=cycles[15:0], 3=cycles[31:16]
- valid  out  1  high in SHOW
- busy  out  1  high in RUN
- err  out  1  sticky timeout flag

Behaviour:
- Reset:
  - All outputs are 0.
  - State IDLE; cycle counter, captured registers and debouncer are cleared.
  - The debouncer comes out of reset in the released state.
- Key path:
  - key_n passes through a 2-FF synchronizer.
  - A debounce counter runs while the synchronized level differs from the debounced level; any return to the debounced level clears the counter.
  - The debounced level flips when the counter reaches DEBOUNCE.
  - `press` is a one-cycle pulse on the debounced high→low transition only.
  - Holding the key yields exactly one press; the next press requires a debounced release first.
- FSM states: IDLE, RUN, SHOW, ERR. All outputs are registered.
- IDLE:
  - start=1 → RUN; cnt<=0.
  - done is ignored in IDLE.
- RUN (busy=1):
  - start=0 → IDLE (abort); no capture.
  - Else done=1 → SHOW: g_q<=g, h_q<=h, cyc_q<=cnt, idx<=0.
  - Else if cnt==TIMEOUT-1 → ERR.
  - Else cnt<=cnt+1.
  - Presses are ignored.
  - Latency definition: cyc_q = number of RUN cycles sampled with done=0. done=1 on the first RUN cycle gives cyc_q=0.
- SHOW (valid=1):
  - start=0 → IDLE; valid, idx and led_val are cleared in the same edge. start=0 takes priority over a simultaneous press.
  - Else press → idx<=idx+1, wrapping 3→0.
  - Further done edges and changes of g/h are ignored; values stay frozen until the next IDLE→RUN.
- ERR:
  - err=1, led_val=16'hDEAD (for WIDTH=16; otherwise all ones).
  - Sticky; exits only on reset. start and done are ignored.
- led_val:
  - Registered mux of {g_q, h_q, cyc_q[15:0], cyc_q[31:16]} by idx.
  - Updates on the cycle after idx changes, and on the cycle after entry to SHOW.
  - Holds 0 in IDLE and RUN.
- cnt is 32 bits and cannot exceed TIMEOUT-1, so no wrap-around is possible.
- Reset asserted mid-RUN or mid-SHOW returns to IDLE immediately, with all outputs 0, regardless of clk.

Test Plan (DEBOUNCE=4, TIMEOUT=100 unless stated):
- Basic capture:
  - Stimulus: reset, start=1, hold done=0 for 7 RUN cycles, then done=1 with g=16'h1234, h=16'h0042.
  - Response: busy high for 8 cycles, then valid=1, idx=0, led_val=16'h1234 one cycle later; cyc_q=7.
- Stepping through slots:
  - Stimulus: from SHOW, four clean key presses (low 10 cycles, high 10 cycles).
  - Response: led_val sequence h=16'h0042, 16'h0007, 16'h0000, then back to 16'h1234; idx 1,2,3,0.
- Bounce and hold:
  - Stimulus: key_n toggles every 2 cycles for 20 cycles, then is held low 50 cycles.
  - Response: exactly one idx increment.
- Timeout:
  - Stimulus: start=1, done never asserted.
  - Response: after 100 RUN cycles, err=1 and led_val=16'hDEAD; a later done=1 and key presses cause no change until rst=0.
- Abort and priority:
  - Stimulus: start dropped mid-RUN, with done asserted on that same cycle.
  - Response: IDLE, valid=0, no capture.
  - Stimulus: in SHOW, start=0 coincident with a press.
  - Response: IDLE, idx=0.
- Immediate done:
  - Stimulus: done already high when start rises.
  - Response: cyc_q=0, reading 16'h0000 at idx=2.
